bcd_alu_arb: RTL
================

BCD_ALU_ARB -- requirements
Module: bcd_alu_arb

Interface
REQ-001 Parameter RR_EN, default 1: 1 = round-robin arbitration; 0 = fixed priority, requester 0 always wins.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  2  bit i = requester i presents an operation.
REQ-005 req_ready  output  2  bit i = requester i's operation accepted this cycle.
REQ-006 req_op  input  4  [1:0] requester 0 opcode, [3:2] requester 1; passed unchanged to BCD_ALU.OP.
REQ-007 req_a  input  32  [15:0] requester 0, [31:16] requester 1; 4-digit BCD operand A.
REQ-008 req_b  input  32  same packing; 4-digit BCD operand B.
REQ-009 rsp_valid  output  2  bit i = result for requester i is held on rsp_data.
REQ-010 rsp_ready  input  2  bit i = requester i consumes the result.
REQ-011 rsp_data  output  16  registered BCD_ALU result C.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, EXEC and RESP.
REQ-014 In IDLE with any req_valid high, the block SHALL choose one winner, drive req_ready[winner]=1 combinationally in that cycle, capture its op/a/b into operand registers and go to EXEC.
REQ-015 req_ready SHALL be one-hot or zero, high only in IDLE, and never high for a requester whose req_valid is low.
REQ-016 In IDLE with both req_valid high, RR_EN=1 SHALL select the requester not most recently granted; RR_EN=0 SHALL select requester 0.
REQ-017 With only one req_valid high, that requester SHALL win regardless of pointer state.
REQ-018 The last-granted pointer SHALL update only on a grant.
REQ-019 In EXEC the shared BCD_ALU instance SHALL see only the registered operands, and its C SHALL be registered into rsp_data at the end of EXEC; the state SHALL then go to RESP.
REQ-020 In RESP, rsp_valid[winner]=1 and rsp_data SHALL hold stable until rsp_ready[winner]=1; that cycle returns to IDLE.
REQ-021 rsp_ready on the non-winning bit SHALL be ignored.
REQ-022 Latency SHALL be fixed: accept in cycle N, rsp_valid in cycle N+2; minimum spacing between grants is 3 cycles.
REQ-023 Operand inputs changing after acceptance SHALL NOT affect the in-flight result.
REQ-024 A req_valid arriving while busy SHALL wait; the block SHALL NOT drop or reorder it relative to arbitration rules.
REQ-025 No arithmetic is done in this block; widths pass through unchanged, no BCD correction added.

Reset
REQ-026 rst high at a clock edge SHALL force IDLE, req_ready=0, rsp_valid=0, rsp_data=16'h0000, busy=0, operand registers to 0, and the pointer to "requester 1 last granted" so requester 0 wins first.
REQ-027 Reset asserted in EXEC or RESP SHALL abort the operation; no rsp_valid for it SHALL appear afterwards.

Structure
REQ-028 A shared package SHALL hold the state encoding (IDLE/EXEC/RESP), the opcode constants (2'b00 add, 2'b11 compare), and the requester count 2.
REQ-029 The block SHALL instantiate exactly one BCD_ALU sub-module; all other logic is local.

Verification
REQ-030 Reset, then requester 0 sends op=00, A=16'h0006, B=16'h0063 -> req_ready=2'b01 same cycle; rsp_valid=2'b01 two cycles later with rsp_data=16'h0069.
REQ-031 Both valid simultaneously: r0 op=11 A=0651 B=0650, r1 op=11 A=0651 B=0652 -> r0 is served first with rsp_data=16'h0001; r1 is served next with 16'hFFFF.
REQ-032 With RR_EN=0, both valid continuously -> only requester 0 is granted; RR_EN=1 -> grants alternate 0,1,0,1.
REQ-033 Hold rsp_ready=0 for 5 cycles in RESP (op=11, A=B=0651) -> rsp_data stays 16'h0000 and rsp_valid stays high; no new grant until the result is consumed.
REQ-034 Change req_a/req_b the cycle after acceptance -> the result reflects the captured operands.
REQ-035 Assert rst in EXEC -> next cycle all outputs are at reset values; no stale rsp_valid, and requester 0 wins the next grant.

Source files
------------

// File: rtl/bcd_alu_arb_pkg.sv
// Shared definitions for the two-requester BCD ALU arbiter: FSM state
// encoding, opcode constants, requester count and a BCD digit adder.
package bcd_alu_arb_pkg;

  localparam int N_REQ  = 2;
  localparam int DIGITS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // 00 = BCD add, 01 = BCD subtract (ten's complement, modulo 10^4),
  // 10 = pass A through, 11 = compare (A>B -> 0001, A<B -> FFFF, else 0000).
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_PASS = 2'b10;
  localparam logic [1:0] OP_CMP  = 2'b11;

  // One decimal digit add with carry; result is {carry_out, sum_digit}.
  function automatic logic [4:0] bcd_digit_add(input logic [3:0] a,
                                               input logic [3:0] b,
                                               input logic       cin);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    if (s > 5'd9) s = s + 5'd6;
    return s;
  endfunction

endpackage

// File: rtl/bcd_alu_arb_alu.sv
// Combinational 4-digit BCD ALU shared by both requesters.
module bcd_alu_arb_alu
  import bcd_alu_arb_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] c
);

  logic [15:0] b_eff;
  logic [15:0] sum;
  logic        carry;
  logic [4:0]  dsum;

  // Digit-serial BCD add; subtract reuses it with the nines complement of B and carry-in 1.
  always_comb begin
    b_eff = b;
    sum   = '0;
    carry = (op == OP_SUB);
    dsum  = '0;
    if (op == OP_SUB) begin
      for (int i = 0; i < DIGITS; i++) b_eff[4*i +: 4] = 4'd9 - b[4*i +: 4];
    end
    for (int i = 0; i < DIGITS; i++) begin
      dsum            = bcd_digit_add(a[4*i +: 4], b_eff[4*i +: 4], carry);
      sum[4*i +: 4]   = dsum[3:0];
      carry           = dsum[4];
    end
    case (op)
      OP_ADD, OP_SUB: c = sum;
      OP_PASS:        c = a;
      default:        c = (a > b) ? 16'h0001 : ((a < b) ? 16'hFFFF : 16'h0000);
    endcase
  end

endmodule

// File: rtl/bcd_alu_arb.sv
// Two-requester front end for one shared BCD ALU. One operation is in flight
// at a time: IDLE grants, EXEC computes from captured operands, RESP holds the
// result for the winner.
// Handshake: a request transfers in the cycle req_valid[i] && req_ready[i];
// a response transfers in the cycle rsp_valid[i] && rsp_ready[i]. Valid never
// depends on the matching ready, and the response payload stays stable while
// rsp_valid is high.
module bcd_alu_arb
  import bcd_alu_arb_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req_valid,
  output logic [N_REQ-1:0]  req_ready,
  input  logic [3:0]        req_op,
  input  logic [31:0]       req_a,
  input  logic [31:0]       req_b,
  output logic [N_REQ-1:0]  rsp_valid,
  input  logic [N_REQ-1:0]  rsp_ready,
  output logic [15:0]       rsp_data,
  output logic              busy,
  output state_e            dbg_state
);

  state_e      state_q, state_d;
  logic        last_q, last_d;      // index of the most recently granted requester
  logic        win_q, win_d;        // index of the requester currently being served
  logic [1:0]  op_q, op_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic [1:0]  grant;
  logic [15:0] alu_c;

  bcd_alu_arb_alu u_alu (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .c  (alu_c)
  );

  // Pick a winner in IDLE: a lone requester always wins; on contention RR favours the other one.
  always_comb begin
    grant = 2'b00;
    if (state_q == IDLE && !rst) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ((RR_EN != 0) && !last_q) ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  // Next-state logic: capture operands on grant, latch the ALU result after EXEC, wait for consume.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    win_d      = win_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          state_d = EXEC;
          win_d   = grant[1];
          last_d  = grant[1];
          op_d    = grant[1] ? req_op[3:2]  : req_op[1:0];
          a_d     = grant[1] ? req_a[31:16] : req_a[15:0];
          b_d     = grant[1] ? req_b[31:16] : req_b[15:0];
        end
      end
      EXEC: begin
        rsp_data_d = alu_c;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready[win_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset leaves requester 1 as last granted so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      win_q      <= 1'b0;
      op_q       <= 2'b00;
      a_q        <= 16'h0000;
      b_q        <= 16'h0000;
      rsp_data_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      win_q      <= win_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign req_ready = grant;
  assign rsp_valid = (state_q == RESP) ? (win_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule
